// File: rtl/key_expander.sv
// AES-128 key schedule: captures a cipher key on a start edge, expands it into
// 11 round keys at one round per cycle, stores them and pulses chg_key_done.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   change_key_start  - level request; its rising edge (in IDLE) starts expansion
//   key_in[127:0]     - cipher key, w0 = key_in[127:96] .. w3 = key_in[31:0]
//   rk_sel[3:0]       - round-key index 0..10 (11..15 read as zero)
//   rk_out[127:0]     - combinational read of the selected round key
//   chg_key_done      - one-cycle pulse once all 11 round keys are written
//   busy              - high while expanding and during the done cycle
//   keys_valid        - stored round keys belong to the most recently loaded key
module key_expander #(
  parameter int unsigned NR = 10,
  localparam int unsigned KEY_W = 128,
  localparam int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_key_start,
  input  logic [KEY_W-1:0] key_in,
  input  logic [SEL_W-1:0] rk_sel,
  output logic [KEY_W-1:0] rk_out,
  output logic             chg_key_done,
  output logic             busy,
  output logic             keys_valid
);

  localparam int unsigned RND_W = SEL_W;

  // Only the AES-128 schedule is implemented.
  if (NR != 10) begin : g_nr_check
    $error("key_expander: only NR=10 (AES-128) is supported");
  end

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } state_t;

  // Four parallel S-box lookups.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Round constant for round r (1..10).
  function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t           state_q;
  state_t           state_n;
  logic [RND_W-1:0] rnd_q;
  logic             start_q;
  logic [KEY_W-1:0] rk_q [0:NR];

  logic             trigger;
  logic             load;
  logic             expand_en;
  logic             last_rnd;
  logic [KEY_W-1:0] prev_rk;
  logic [KEY_W-1:0] next_rk;
  logic [31:0]      w3;
  logic [31:0]      t_word;
  logic [31:0]      n0, n1, n2, n3;

  assign trigger  = change_key_start & ~start_q;
  assign last_rnd = (rnd_q == RND_W'(NR));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Next-state and datapath controls.
  always_comb begin
    state_n   = state_q;
    load      = 1'b0;
    expand_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          load    = 1'b1;
          state_n = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        expand_en = 1'b1;
        if (last_rnd) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Previous round key, selected by the current round counter.
  always_comb begin
    prev_rk = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (rnd_q == RND_W'(i + 1)) prev_rk = rk_q[i];
    end
  end

  // One AES-128 key-schedule round.
  assign w3     = prev_rk[31:0];
  assign t_word = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd_q), 24'h0};
  assign n0     = prev_rk[127:96] ^ t_word;
  assign n1     = prev_rk[95:64]  ^ n0;
  assign n2     = prev_rk[63:32]  ^ n1;
  assign n3     = w3              ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // Round-key storage, round counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
      rnd_q        <= '0;
      start_q      <= 1'b0;
      keys_valid   <= 1'b0;
      chg_key_done <= 1'b0;
      busy         <= 1'b0;
    end else begin
      start_q      <= change_key_start;
      busy         <= (state_n != ST_IDLE);
      chg_key_done <= (state_n == ST_DONE);
      if (load) begin
        rk_q[0]    <= key_in;
        rnd_q      <= RND_W'(1);
        keys_valid <= 1'b0;
      end
      if (expand_en) begin
        for (int unsigned i = 1; i <= NR; i++) begin
          if (rnd_q == RND_W'(i)) rk_q[i] <= next_rk;
        end
        rnd_q <= last_rnd ? '0 : rnd_q + RND_W'(1);
        if (last_rnd) keys_valid <= 1'b1;
      end
    end
  end

  // Ungated read port; consumers qualify with keys_valid.
  always_comb begin
    rk_out = '0;
    for (int unsigned i = 0; i <= NR; i++) begin
      if (rk_sel == SEL_W'(i)) rk_out = rk_q[i];
    end
  end

endmodule

// File: tb/tb_key_expander.sv
// Scoreboard bench for key_expander: stimulus queues expected values, a monitor
// on the falling edge pops and compares them, and tracks done-pulse timing.
module tb_key_expander;

  localparam int SIG_RK   = 0;
  localparam int SIG_BUSY = 1;
  localparam int SIG_KV   = 2;
  localparam int SIG_DONE = 3;

  localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK2   = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst;
  logic         change_key_start;
  logic [127:0] key_in;
  logic [3:0]   rk_sel;
  logic [127:0] rk_out;
  logic         chg_key_done;
  logic         busy;
  logic         keys_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int           done_q [$];
  string        name_q [$];
  int           sig_q  [$];
  logic [127:0] val_q  [$];

  key_expander #(.NR(10)) dut (
    .clk              (clk),
    .rst              (rst),
    .change_key_start (change_key_start),
    .key_in           (key_in),
    .rk_sel           (rk_sel),
    .rk_out           (rk_out),
    .chg_key_done     (chg_key_done),
    .busy             (busy),
    .keys_valid       (keys_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks done pulses against expected cycles and drains queued expectations.
  string        mon_name;
  int           mon_sig;
  int           mon_exp_cyc;
  logic [127:0] mon_val;
  logic [127:0] mon_act;
  always @(negedge clk) begin
    if (chg_key_done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        mon_exp_cyc = done_q.pop_front();
        if (cyc != mon_exp_cyc) begin
          failures++;
          $display("FAIL done_latency: actual cycle %0d required %0d", cyc, mon_exp_cyc);
        end
      end
    end
    while (name_q.size() > 0) begin
      mon_name = name_q.pop_front();
      mon_sig  = sig_q.pop_front();
      mon_val  = val_q.pop_front();
      case (mon_sig)
        SIG_RK:   mon_act = rk_out;
        SIG_BUSY: mon_act = 128'(busy);
        SIG_KV:   mon_act = 128'(keys_valid);
        default:  mon_act = 128'(chg_key_done);
      endcase
      checks++;
      if (mon_act !== mon_val) begin
        failures++;
        $display("FAIL %s: actual=%h required=%h", mon_name, mon_act, mon_val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input string name, input int sig, input logic [127:0] val);
    name_q.push_back(name);
    sig_q.push_back(sig);
    val_q.push_back(val);
  endtask

  task automatic expect_status(input string pfx, input logic b, input logic kv);
    expect_sig({pfx, "_busy"}, SIG_BUSY, 128'(b));
    expect_sig({pfx, "_keys_valid"}, SIG_KV, 128'(kv));
  endtask

  task automatic read_rk(input string name, input logic [3:0] sel, input logic [127:0] val);
    rk_sel = sel;
    expect_sig(name, SIG_RK, val);
    tick();
  endtask

  // Raise the request; E0 is the next rising edge, done lands 11 cycles later.
  task automatic start_key(input logic [127:0] k);
    key_in           = k;
    change_key_start = 1'b1;
    done_q.push_back(cyc + 11);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (done_q.size() != 0) begin
      failures++;
      $display("FAIL %s: pending done pulses=%0d required=0", name, done_q.size());
      done_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    change_key_start = 1'b0;
    key_in = '0;
    rk_sel = '0;
    tick();
    tick();

    // Reset state
    expect_status("reset", 1'b0, 1'b0);
    expect_sig("reset_done", SIG_DONE, 128'(0));
    read_rk("reset_rk0", 4'd0, '0);
    read_rk("reset_rk10", 4'd10, '0);
    rst = 1'b0;
    tick();

    // FIPS-197 A.1 key with controller-style handshake (held until after done)
    start_key(A1_KEY);
    tick();
    expect_status("t1_e1", 1'b1, 1'b0);
    repeat (11) tick();
    change_key_start = 1'b0;
    tick();
    expect_status("t1_after", 1'b0, 1'b1);
    check_drained("t1_done_pulse");
    read_rk("t1_rk0", 4'd0, A1_KEY);
    read_rk("t1_rk1", 4'd1, A1_RK1);
    read_rk("t1_rk2", 4'd2, A1_RK2);
    read_rk("t1_rk10", 4'd10, A1_RK10);
    read_rk("t1_rk12", 4'd12, '0);
    repeat (5) tick();
    expect_status("t1_no_reexpand", 1'b0, 1'b1);
    tick();

    // Back-to-back: zero key after A.1; old rk10 readable until overwritten
    start_key('0);
    tick();
    change_key_start = 1'b0;
    expect_status("t2_e1", 1'b1, 1'b0);
    rk_sel = 4'd10;
    expect_sig("t2_old_rk10", SIG_RK, A1_RK10);
    repeat (12) tick();
    expect_status("t2_after", 1'b0, 1'b1);
    check_drained("t2_done_pulse");
    read_rk("t2_rk1", 4'd1, Z_RK1);
    read_rk("t2_rk2", 4'd2, Z_RK2);
    read_rk("t2_rk10", 4'd10, Z_RK10);
    read_rk("t2_rk15", 4'd15, '0);

    // Mid-operation key change is ignored
    start_key(A1_KEY);
    tick();
    change_key_start = 1'b0;
    tick();
    key_in = '0;
    change_key_start = 1'b1;
    tick();
    change_key_start = 1'b0;
    repeat (10) tick();
    expect_status("t3_after", 1'b0, 1'b1);
    check_drained("t3_done_pulse");
    read_rk("t3_rk0", 4'd0, A1_KEY);
    read_rk("t3_rk1", 4'd1, A1_RK1);
    read_rk("t3_rk10", 4'd10, A1_RK10);
    repeat (3) tick();

    // Reset mid-expansion, then retrigger from a level held across reset release
    start_key('0);
    tick();
    change_key_start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    done_q.delete();
    expect_status("t4_rst", 1'b0, 1'b0);
    expect_sig("t4_rst_done", SIG_DONE, 128'(0));
    tick();
    for (int i = 0; i <= 11; i++) begin
      read_rk($sformatf("t4_rst_rk%0d", i), 4'(i), '0);
    end
    key_in = A1_KEY;
    change_key_start = 1'b1;
    tick();
    rst = 1'b0;
    done_q.push_back(cyc + 11);
    tick();
    change_key_start = 1'b0;
    repeat (11) tick();
    expect_status("t4_after", 1'b0, 1'b1);
    check_drained("t4_done_pulse");
    read_rk("t4_rk0", 4'd0, A1_KEY);
    read_rk("t4_rk1", 4'd1, A1_RK1);
    read_rk("t4_rk10", 4'd10, A1_RK10);

    repeat (4) tick();
    check_drained("final_no_extra_done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
